// File: rtl/bp_pkg.sv
// Shared types and helpers for the fetch-side branch predictor and its later BHT sibling.
package bp_pkg;

    localparam int BP_IDX_W = 6;
    localparam int BP_TAG_W = 12;
    localparam logic [1:0] CTR_WEAK_T = 2'b10;

    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [29:0]         target;
        logic [1:0]          ctr;
    } bp_entry_t;

    // Results are returned right-aligned in 32 bits; callers cast to their own width.
    function automatic logic [31:0] idx_of(input logic [31:0] pc, input int idx_w);
        return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc, input int idx_w, input int tag_w);
        return (pc >> (idx_w + 2)) & ((32'd1 << tag_w) - 32'd1);
    endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Combinational 2-bit saturating up/down counter step, shared by the BTB and the future BHT.
module bp_sat_ctr (
    input  logic [1:0] ctr_in,
    input  logic       inc,
    output logic [1:0] ctr_out
);

    always_comb begin
        ctr_out = ctr_in;
        if (inc) begin
            if (ctr_in != 2'b11) ctr_out = ctr_in + 2'd1;
        end else begin
            if (ctr_in != 2'b00) ctr_out = ctr_in - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, registered lookup and a one-entry
// forwarding write pipeline fed by EX branch resolution.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int IDX_W = BP_IDX_W,
    parameter int TAG_W = BP_TAG_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid,
    input  logic        fetch_stall,
    input  logic [31:0] fetch_pc,
    output logic        predict_to_branch,
    output logic [31:0] pc_predict,
    output logic        pred_valid,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_tpc,
    input  logic        upd_dir_fail,
    input  logic        upd_addr_fail,
    output logic [31:0] mispred_cnt
);

    localparam int DEPTH = 1 << IDX_W;

    logic [DEPTH-1:0] valid_q;
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic [29:0]      target_q [DEPTH];
    logic [1:0]       ctr_q    [DEPTH];

    logic             pend_valid;
    logic [IDX_W-1:0] pend_idx;
    bp_entry_t        pend_entry;

    logic [IDX_W-1:0] l_idx;
    logic [TAG_W-1:0] l_tag;
    bp_entry_t        l_entry;
    logic             l_taken;

    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    bp_entry_t        u_entry;
    bp_entry_t        new_entry;
    logic             u_hit;
    logic             load_pend;
    logic [1:0]       ctr_next;

    logic unused_tpc_lsb;
    assign unused_tpc_lsb = ^upd_tpc[1:0];

    assign l_idx = IDX_W'(idx_of(fetch_pc, IDX_W));
    assign l_tag = TAG_W'(tag_of(fetch_pc, IDX_W, TAG_W));
    assign u_idx = IDX_W'(idx_of(upd_pc, IDX_W));
    assign u_tag = TAG_W'(tag_of(upd_pc, IDX_W, TAG_W));

    // The pending entry commits this cycle, so both readers must see it over the array copy.
    always_comb begin
        if (pend_valid && pend_idx == l_idx) begin
            l_entry = pend_entry;
        end else begin
            l_entry = '{valid: valid_q[l_idx], tag: tag_q[l_idx],
                        target: target_q[l_idx], ctr: ctr_q[l_idx]};
        end
        l_taken = l_entry.valid && (l_entry.tag == l_tag) && l_entry.ctr[1];
    end

    always_comb begin
        if (pend_valid && pend_idx == u_idx) begin
            u_entry = pend_entry;
        end else begin
            u_entry = '{valid: valid_q[u_idx], tag: tag_q[u_idx],
                        target: target_q[u_idx], ctr: ctr_q[u_idx]};
        end
        u_hit = u_entry.valid && (u_entry.tag == u_tag);
    end

    bp_sat_ctr u_sat_ctr (
        .ctr_in  (u_entry.ctr),
        .inc     (upd_taken),
        .ctr_out (ctr_next)
    );

    // A not-taken miss leaves the table alone rather than allocating a useless entry.
    always_comb begin
        new_entry = u_entry;
        load_pend = 1'b0;
        if (u_hit) begin
            new_entry.ctr = ctr_next;
            if (upd_taken) new_entry.target = upd_tpc[31:2];
            load_pend = upd_valid;
        end else if (upd_taken) begin
            new_entry = '{valid: 1'b1, tag: u_tag, target: upd_tpc[31:2], ctr: CTR_WEAK_T};
            load_pend = upd_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (pend_valid) begin
            tag_q[pend_idx]    <= pend_entry.tag;
            target_q[pend_idx] <= pend_entry.target;
            ctr_q[pend_idx]    <= pend_entry.ctr;
        end
        if (load_pend) begin
            pend_idx   <= u_idx;
            pend_entry <= new_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q           <= '0;
            pend_valid        <= 1'b0;
            pred_valid        <= 1'b0;
            predict_to_branch <= 1'b0;
            pc_predict        <= '0;
            mispred_cnt       <= '0;
        end else begin
            if (pend_valid) valid_q[pend_idx] <= pend_entry.valid;
            pend_valid <= load_pend;
            if (upd_valid && (upd_dir_fail || upd_addr_fail)) mispred_cnt <= mispred_cnt + 32'd1;
            if (!fetch_stall) begin
                if (fetch_valid) begin
                    pred_valid        <= 1'b1;
                    predict_to_branch <= l_taken;
                    pc_predict        <= l_taken ? {l_entry.target, 2'b00} : fetch_pc + 32'd4;
                end else begin
                    pred_valid        <= 1'b0;
                    predict_to_branch <= 1'b0;
                end
            end
        end
    end

endmodule
